ctrl_bubble_pipe: RTL and testbench

- Parametrised successor to the control-unit bubble mux.
- Carries the decoded control word through STAGES pipeline registers (EX/MEM/WB for STAGES=3).
- Inserts NOP bubbles at the head on a hazard or on a multi-cycle inject request.
- Supports per-stage hold and flush, emits a valid bit per stage, and counts bubbles inserted at the head.
- Sits between the control unit and the datapath stage registers.

---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/ctrl_stage_reg.sv | 58 +++++
 rtl/ctrl_bubble_pipe.sv | 130 +++++++++++++
 tb/tb_ctrl_bubble_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word bubble pipeline: control-word field
// layout, default width and the NOP word.
package ctrl_pkg;

  localparam int CW_DEFAULT = 21;

  // Field offsets/widths, MSB to LSB: SRD, PSW_LE_RE, B, SOH_OP, ALU_OP, RAM_CTRL, L, RF_LE, ID_SR, UB
  localparam int UB_LSB        = 0;
  localparam int UB_W          = 1;
  localparam int ID_SR_LSB     = 1;
  localparam int ID_SR_W       = 2;
  localparam int RF_LE_LSB     = 3;
  localparam int RF_LE_W       = 1;
  localparam int L_LSB         = 4;
  localparam int L_W           = 1;
  localparam int RAM_CTRL_LSB  = 5;
  localparam int RAM_CTRL_W    = 4;
  localparam int ALU_OP_LSB    = 9;
  localparam int ALU_OP_W      = 4;
  localparam int SOH_OP_LSB    = 13;
  localparam int SOH_OP_W      = 3;
  localparam int B_LSB         = 16;
  localparam int B_W           = 1;
  localparam int PSW_LE_RE_LSB = 17;
  localparam int PSW_LE_RE_W   = 2;
  localparam int SRD_LSB       = 19;
  localparam int SRD_W         = 2;

  localparam logic [CW_DEFAULT-1:0] NOP_WORD = {CW_DEFAULT{1'b0}};

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage of the control word: flush beats hold, hold beats the
// bubble-behind-a-held-stage case, otherwise the upstream word is loaded.
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int            CW       = CW_DEFAULT,
  parameter logic [CW-1:0] NOP_WORD = {CW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          hold,
  input  logic          bubble,
  input  logic [CW-1:0] d,
  input  logic          d_valid,
  output logic [CW-1:0] q,
  output logic          q_valid
);

  logic [CW-1:0] word_r;
  logic          valid_r;
  logic [CW-1:0] word_nxt_s;
  logic          valid_nxt_s;

  // Next-state select for the stage contents
  always_comb begin
    word_nxt_s  = word_r;
    valid_nxt_s = valid_r;
    if (flush) begin
      word_nxt_s  = NOP_WORD;
      valid_nxt_s = 1'b0;
    end else if (hold) begin
      word_nxt_s  = word_r;
      valid_nxt_s = valid_r;
    end else if (bubble) begin
      word_nxt_s  = NOP_WORD;
      valid_nxt_s = 1'b0;
    end else begin
      word_nxt_s  = d;
      valid_nxt_s = d_valid;
    end
  end

  // Stage register with asynchronous reset to NOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r  <= NOP_WORD;
      valid_r <= 1'b0;
    end else begin
      word_r  <= word_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign q       = word_r;
  assign q_valid = valid_r;

endmodule

// File: rtl/ctrl_bubble_pipe.sv
// Control-word pipeline between control unit and datapath: head bubble
// insertion (hazard / multi-cycle inject), per-stage hold and flush, bubble count.
module ctrl_bubble_pipe
  import ctrl_pkg::*;
#(
  parameter int            CW       = CW_DEFAULT,
  parameter int            STAGES   = 3,
  parameter logic [CW-1:0] NOP_WORD = {CW{1'b0}},
  parameter int            LEN_W    = 3,
  parameter int            CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CW-1:0]        ctrl_in,
  input  logic                 ctrl_valid_in,
  output logic                 in_ready,
  input  logic                 hazard_i,
  input  logic                 inject_i,
  input  logic [LEN_W-1:0]     inject_len,
  input  logic [STAGES-1:0]    hold_i,
  input  logic [STAGES-1:0]    flush_i,
  input  logic                 cnt_clr_i,
  output logic [STAGES*CW-1:0] ctrl_out,
  output logic [STAGES-1:0]    valid_out,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [STAGES-1:0] hold_eff_s;
  logic [LEN_W-1:0]  inj_cnt_r;
  logic [LEN_W-1:0]  inj_cnt_nxt_s;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic [CNT_W-1:0]  bubble_cnt_nxt_s;
  logic              inj_busy_s;
  logic              head_nop_s;
  logic              adv0_s;
  logic [CW-1:0]     head_word_s;
  logic              head_valid_s;
  logic [CW-1:0]     stage_word_s  [STAGES];
  logic              stage_valid_s [STAGES];

  // A hold anywhere downstream freezes every stage upstream of it
  always_comb begin
    hold_eff_s = hold_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      hold_eff_s[k] = hold_i[k] | hold_eff_s[k+1];
    end
  end

  assign inj_busy_s   = (inj_cnt_r != {LEN_W{1'b0}});
  assign head_nop_s   = hazard_i | inj_busy_s;
  assign head_word_s  = head_nop_s ? NOP_WORD : ctrl_in;
  assign head_valid_s = ~head_nop_s & ctrl_valid_in;
  assign adv0_s       = ~flush_i[0] & ~hold_eff_s[0];
  assign in_ready     = ~hold_eff_s[0] & ~hazard_i & ~inj_busy_s;

  // Inject counter: load only when idle, count down only when stage 0 advances
  always_comb begin
    inj_cnt_nxt_s = inj_cnt_r;
    if (!inj_busy_s) begin
      if (inject_i) begin
        inj_cnt_nxt_s = inject_len;
      end else begin
        inj_cnt_nxt_s = inj_cnt_r;
      end
    end else if (adv0_s) begin
      inj_cnt_nxt_s = inj_cnt_r - LEN_ONE;
    end else begin
      inj_cnt_nxt_s = inj_cnt_r;
    end
  end

  // Saturating head-bubble counter with clear taking priority
  always_comb begin
    bubble_cnt_nxt_s = bubble_cnt_r;
    if (cnt_clr_i) begin
      bubble_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (adv0_s && head_nop_s && !(&bubble_cnt_r)) begin
      bubble_cnt_nxt_s = bubble_cnt_r + CNT_ONE;
    end else begin
      bubble_cnt_nxt_s = bubble_cnt_r;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_cnt_r    <= {LEN_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      inj_cnt_r    <= inj_cnt_nxt_s;
      bubble_cnt_r <= bubble_cnt_nxt_s;
    end
  end

  assign bubble_cnt = bubble_cnt_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      ctrl_stage_reg #(.CW(CW), .NOP_WORD(NOP_WORD)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush_i[0]),
        .hold    (hold_eff_s[0]),
        .bubble  (1'b0),
        .d       (head_word_s),
        .d_valid (head_valid_s),
        .q       (stage_word_s[0]),
        .q_valid (stage_valid_s[0])
      );
    end else begin : g_body
      ctrl_stage_reg #(.CW(CW), .NOP_WORD(NOP_WORD)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush_i[k]),
        .hold    (hold_eff_s[k]),
        .bubble  (hold_eff_s[k-1]),
        .d       (stage_word_s[k-1]),
        .d_valid (stage_valid_s[k-1]),
        .q       (stage_word_s[k]),
        .q_valid (stage_valid_s[k])
      );
    end
    assign ctrl_out[k*CW +: CW] = stage_word_s[k];
    assign valid_out[k]         = stage_valid_s[k];
  end

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Scoreboard bench for ctrl_bubble_pipe: directed scenarios plus random
// stimulus, checked against a cycle-level behavioural model.
module tb_ctrl_bubble_pipe;
  import ctrl_pkg::*;

  localparam int CW = 21;
  localparam int ST = 3;
  localparam int LW = 3;
  localparam int CN = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CW-1:0]    ctrl_in = '0;
  logic             ctrl_valid_in = 1'b0;
  logic             in_ready;
  logic             hazard_i = 1'b0;
  logic             inject_i = 1'b0;
  logic [LW-1:0]    inject_len = '0;
  logic [ST-1:0]    hold_i = '0;
  logic [ST-1:0]    flush_i = '0;
  logic             cnt_clr_i = 1'b0;
  logic [ST*CW-1:0] ctrl_out;
  logic [ST-1:0]    valid_out;
  logic [CN-1:0]    bubble_cnt;

  ctrl_bubble_pipe #(.CW(CW), .STAGES(ST), .LEN_W(LW), .CNT_W(CN)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .ctrl_valid_in(ctrl_valid_in),
    .in_ready(in_ready), .hazard_i(hazard_i), .inject_i(inject_i),
    .inject_len(inject_len), .hold_i(hold_i), .flush_i(flush_i),
    .cnt_clr_i(cnt_clr_i), .ctrl_out(ctrl_out), .valid_out(valid_out),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             ready;
    logic [ST*CW-1:0] ctrl;
    logic [ST-1:0]    valid;
    logic [CN-1:0]    cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: plain arrays and integers
  logic [CW-1:0] m_word [ST];
  logic          m_val  [ST];
  int            m_inj;
  int            m_bcnt;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ST; k++) begin
      m_word[k] = '0;
      m_val[k]  = 1'b0;
    end
    m_inj  = 0;
    m_bcnt = 0;
  endtask

  // Drive one cycle of inputs just after an edge and predict the next edge
  task automatic step(input logic [CW-1:0] w, input logic v, input logic hz,
                      input logic inj, input logic [LW-1:0] len,
                      input logic [ST-1:0] hold, input logic [ST-1:0] flush,
                      input logic clr, input logic sat);
    exp_t          e;
    logic [ST-1:0] heff;
    logic [CW-1:0] nw [ST];
    logic          nv [ST];
    bit            head_nop;
    bit            adv0;
    @(posedge clk);
    #2;
    ctrl_in = w; ctrl_valid_in = v; hazard_i = hz; inject_i = inj;
    inject_len = len; hold_i = hold; flush_i = flush; cnt_clr_i = clr;
    if (sat) begin
      force dut.bubble_cnt_r = 16'hFFFF;
      #1;
      release dut.bubble_cnt_r;
      m_bcnt = 65535;
    end
    for (int k = 0; k < ST; k++) heff[k] = ((hold >> k) != '0);
    head_nop = hz || (m_inj != 0);
    e.ready  = !heff[0] && !hz && (m_inj == 0);
    for (int k = 0; k < ST; k++) begin
      if (flush[k]) begin
        nw[k] = '0; nv[k] = 1'b0;
      end else if (heff[k]) begin
        nw[k] = m_word[k]; nv[k] = m_val[k];
      end else if (k == 0) begin
        nw[k] = head_nop ? '0 : w;
        nv[k] = !head_nop && v;
      end else if (heff[k-1]) begin
        nw[k] = '0; nv[k] = 1'b0;
      end else begin
        nw[k] = m_word[k-1]; nv[k] = m_val[k-1];
      end
    end
    adv0 = !flush[0] && !heff[0];
    if (m_inj == 0) begin
      if (inj) m_inj = int'(len);
    end else if (adv0) begin
      m_inj = m_inj - 1;
    end
    if (clr) m_bcnt = 0;
    else if (adv0 && head_nop && m_bcnt < 65535) m_bcnt = m_bcnt + 1;
    for (int k = 0; k < ST; k++) begin
      m_word[k] = nw[k];
      m_val[k]  = nv[k];
      e.ctrl[k*CW +: CW] = nw[k];
      e.valid[k] = nv[k];
    end
    e.cnt = m_bcnt[CN-1:0];
    sb_q.push_back(e);
  endtask

  task automatic rand_step();
    logic [ST-1:0] hold;
    logic [ST-1:0] flush;
    for (int k = 0; k < ST; k++) begin
      hold[k]  = ($urandom_range(0, 7) == 0);
      flush[k] = ($urandom_range(0, 15) == 0);
    end
    step(CW'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
         $urandom_range(0, 11) == 0, LW'($urandom), hold, flush,
         $urandom_range(0, 31) == 0, 1'b0);
  endtask

  // Monitor: in_ready mid-cycle, registered outputs just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q[0];
        chk("in_ready", 64'(in_ready), 64'(e.ready));
        @(posedge clk);
        #1;
        chk("ctrl_out", 64'(ctrl_out), 64'(e.ctrl));
        chk("valid_out", 64'(valid_out), 64'(e.valid));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #12;
    chk("reset_ctrl", 64'(ctrl_out), 64'd0);
    chk("reset_valid", 64'(valid_out), 64'd0);
    chk("reset_cnt", 64'(bubble_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Plain stream
    step(21'h00001, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    step(21'h00002, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    step(21'h00003, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    // One hazard cycle
    step(21'h00004, 1'b1, 1'b1, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("stream_words", 64'(ctrl_out), 64'({21'h00001, 21'h00002, 21'h00003}));
    chk("stream_valid", 64'(valid_out), 64'(3'b111));
    step(21'h00004, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("hazard_valid", 64'(valid_out), 64'(3'b110));
    chk("hazard_cnt", 64'(bubble_cnt), 64'd1);
    step(21'h00005, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    step(21'h00006, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    // Middle-stage hold for two cycles
    step(21'h00007, 1'b1, 1'b0, 1'b0, 3'd0, 3'b010, 3'b000, 1'b0, 1'b0);
    step(21'h00007, 1'b1, 1'b0, 1'b0, 3'd0, 3'b010, 3'b000, 1'b0, 1'b0);
    step(21'h00007, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("hold_stage2_nop", 64'(ctrl_out[2*CW +: CW]), 64'd0);
    step(21'h00008, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    // Inject three bubbles with a head hold in the middle
    step(21'h00009, 1'b1, 1'b0, 1'b1, 3'd3, 3'b000, 3'b000, 1'b0, 1'b0);
    step(21'h0000A, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    step(21'h0000A, 1'b1, 1'b0, 1'b0, 3'd0, 3'b001, 3'b000, 1'b0, 1'b0);
    step(21'h0000A, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    step(21'h0000A, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    step(21'h0000A, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("inject_cnt", 64'(bubble_cnt), 64'd4);
    // Flush beats hold
    step(21'h0000B, 1'b1, 1'b0, 1'b0, 3'd0, 3'b001, 3'b011, 1'b0, 1'b0);
    step(21'h0000C, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("flush_valid", 64'(valid_out[1:0]), 64'(2'b00));
    // Saturation then clear
    step(21'h0000D, 1'b1, 1'b1, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b1);
    step(21'h0000D, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("sat_cnt", 64'(bubble_cnt), 64'hFFFF);
    step(21'h0000E, 1'b1, 1'b1, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("clr_cnt", 64'(bubble_cnt), 64'd0);

    for (int i = 0; i < 400; i++) rand_step();

    // Reset mid-stream with an injection in progress
    for (int i = 0; i < 4; i++)
      step(CW'($urandom), 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    step(21'h1ABCD, 1'b1, 1'b1, 1'b1, 3'd7, 3'b000, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    ctrl_in = '0; ctrl_valid_in = 1'b0; hazard_i = 1'b0; inject_i = 1'b0;
    inject_len = '0; hold_i = '0; flush_i = '0; cnt_clr_i = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'(ctrl_out), 64'd0);
    chk("async_reset_valid", 64'(valid_out), 64'd0);
    chk("async_reset_cnt", 64'(bubble_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(21'h00111, 1'b1, 1'b0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) rand_step();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
